// File: rtl/weight_pingpong_ctrl.sv
// Double-buffered weight SRAM sequencer: streams external words into the fill half and hands full halves to compute.
// Optional WEIGHT_PP_CHECKSUM_EN builds a per-load 32-bit wrap-around sum of the streamed words.
module weight_pingpong_ctrl #(
  parameter int unsigned TOTAL_WEIGHT_MEMORY_SIZE = 16384,
  parameter int unsigned BIT_WIDTH_EXTERNAL_PORT  = 32,
  parameter int unsigned WEIGHT_MEMORY_ADDR_SIZE  = 14,
  parameter int unsigned LOAD_LEN_BITS            = 12
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               load_start,
  input  logic [LOAD_LEN_BITS-1:0]           load_words,
  input  logic                               ext_valid,
  input  logic [BIT_WIDTH_EXTERNAL_PORT-1:0] ext_data,
  output logic                               ext_ready,
  output logic                               wr_en,
  output logic [WEIGHT_MEMORY_ADDR_SIZE-1:0] wr_addr,
  output logic [BIT_WIDTH_EXTERNAL_PORT-1:0] wr_data,
  output logic                               load_busy,
  output logic                               cfg_err,
  input  logic                               comp_req,
  output logic                               comp_grant,
  output logic [WEIGHT_MEMORY_ADDR_SIZE-1:0] comp_base,
  input  logic                               comp_done,
  output logic [1:0]                         buf_full,
  output logic [BIT_WIDTH_EXTERNAL_PORT-1:0] load_checksum
);

  localparam int unsigned BUF_BYTES  = TOTAL_WEIGHT_MEMORY_SIZE / 2;
  localparam int unsigned BUF_WORDS  = BUF_BYTES * 8 / BIT_WIDTH_EXTERNAL_PORT;
  localparam int unsigned BYTE_SHIFT = $clog2(BIT_WIDTH_EXTERNAL_PORT / 8);
  localparam int unsigned WORD_BITS  = WEIGHT_MEMORY_ADDR_SIZE - 1 - BYTE_SHIFT;
  localparam logic [LOAD_LEN_BITS:0] MAX_LEN = (LOAD_LEN_BITS + 1)'(BUF_WORDS);

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_IN_USE} bstate_t;
  typedef enum logic [1:0] {L_IDLE, L_WAIT, L_FILL} lstate_t;
  typedef enum logic {C_IDLE, C_ACTIVE} cstate_t;

  bstate_t bstate [2];
  lstate_t l_state, l_next;
  cstate_t c_state, c_next;
  logic    fill_sel, comp_sel;
  logic [LOAD_LEN_BITS-1:0] load_len, count;
  logic    accept, bad_len, fill_enter, xfer, last, grant, comp_free;

  always_comb begin
    l_next     = l_state;
    accept     = 1'b0;
    bad_len    = 1'b0;
    xfer       = 1'b0;
    last       = 1'b0;
    case (l_state)
      L_IDLE: if (load_start) begin
        if (load_words != '0 && {1'b0, load_words} <= MAX_LEN) begin
          accept = 1'b1;
          l_next = (bstate[fill_sel] == B_EMPTY) ? L_FILL : L_WAIT;
        end else begin
          bad_len = 1'b1;
        end
      end
      L_WAIT: if (bstate[fill_sel] == B_EMPTY) l_next = L_FILL;
      L_FILL: if (ext_valid) begin
        xfer = 1'b1;
        if (count == load_len - 1'b1) begin
          last   = 1'b1;
          l_next = L_IDLE;
        end
      end
      default: l_next = L_IDLE;
    endcase
    fill_enter = (l_state != L_FILL) && (l_next == L_FILL);

    c_next    = c_state;
    grant     = 1'b0;
    comp_free = 1'b0;
    case (c_state)
      C_IDLE: if (comp_req && bstate[comp_sel] == B_FULL) begin
        grant  = 1'b1;
        c_next = C_ACTIVE;
      end
      C_ACTIVE: if (comp_done) begin
        comp_free = 1'b1;
        c_next    = C_IDLE;
      end
      default: c_next = C_IDLE;
    endcase
  end

  assign ext_ready = (l_state == L_FILL);
  assign load_busy = (l_state != L_IDLE);

  always_comb begin
    buf_full = '0;
    for (int unsigned i = 0; i < 2; i++)
      buf_full[i] = (bstate[i] == B_FULL) || (bstate[i] == B_IN_USE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      l_state    <= L_IDLE;
      c_state    <= C_IDLE;
      bstate[0]  <= B_EMPTY;
      bstate[1]  <= B_EMPTY;
      fill_sel   <= 1'b0;
      comp_sel   <= 1'b0;
      load_len   <= '0;
      count      <= '0;
      cfg_err    <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      comp_grant <= 1'b0;
      comp_base  <= '0;
    end else begin
      l_state    <= l_next;
      c_state    <= c_next;
      wr_en      <= xfer;
      comp_grant <= grant;
      if (bad_len) cfg_err <= 1'b1;
      if (accept) begin
        load_len <= load_words;
        count    <= '0;
      end
      if (xfer) begin
        count   <= count + 1'b1;
        wr_data <= ext_data;
        wr_addr <= {fill_sel, count[WORD_BITS-1:0], {BYTE_SHIFT{1'b0}}};
      end
      // Loader and compute never touch the same buffer in one cycle, so these updates do not collide.
      if (fill_enter) bstate[fill_sel] <= B_FILLING;
      if (last) begin
        bstate[fill_sel] <= B_FULL;
        fill_sel         <= ~fill_sel;
      end
      if (grant) begin
        bstate[comp_sel] <= B_IN_USE;
        comp_base        <= {comp_sel, {(WEIGHT_MEMORY_ADDR_SIZE-1){1'b0}}};
      end
      if (comp_free) begin
        bstate[comp_sel] <= B_EMPTY;
        comp_sel         <= ~comp_sel;
      end
    end
  end

`ifdef WEIGHT_PP_CHECKSUM_EN
  logic [BIT_WIDTH_EXTERNAL_PORT-1:0] sum;

  always_ff @(posedge clk) begin
    if (reset) begin
      sum           <= '0;
      load_checksum <= '0;
    end else begin
      if (accept)    sum <= '0;
      else if (xfer) sum <= sum + ext_data;
      if (last) load_checksum <= sum + ext_data;
    end
  end
`else
  assign load_checksum = '0;
`endif

endmodule
